// File: rtl/apu_core_package.sv
// Shared APU sizing constants and the core-ID / arbiter-state types
// used by the cluster APU sharing logic.
package apu_core_package;

  localparam int APU_NARGS        = 3;
  localparam int APU_WARG         = 32;
  localparam int APU_OP_W         = APU_NARGS * APU_WARG;
  localparam int APU_RES_W        = 32;
  localparam int NUM_CORES_DEF    = 4;
  localparam int MAX_INFLIGHT_DEF = 4;

  typedef logic [$clog2(NUM_CORES_DEF)-1:0] core_id_t;

  typedef enum logic {
    ARB_OPEN,
    ARB_LOCKED
  } arb_state_e;

endpackage

// File: rtl/apu_order_fifo.sv
// In-order FIFO holding the core IDs of ops issued to the shared APU.
// Push is ignored when full and pop is ignored when empty.
module apu_order_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   i_push,
  input  logic [DATA_W-1:0]      i_data,
  input  logic                   i_pop,
  output logic [DATA_W-1:0]      o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [PTR_W:0]    r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rdPtr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wrPtr] <= i_data;
  end

endmodule

// File: rtl/apu_shared_arbiter.sv
// Shares one APU between NUM_CORES cores: round-robin issue with a grant lock,
// and in-order routing of results back to the issuing core.
module apu_shared_arbiter
  import apu_core_package::*;
#(
  parameter int NUM_CORES    = NUM_CORES_DEF,
  parameter int OP_W         = APU_OP_W,
  parameter int RES_W        = APU_RES_W,
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_CORES-1:0]      core_req_i,
  input  logic [NUM_CORES*OP_W-1:0] core_op_i,
  output logic [NUM_CORES-1:0]      core_gnt_o,
  output logic [NUM_CORES-1:0]      core_valid_o,
  output logic [RES_W-1:0]          core_result_o,
  output logic                      apu_req_o,
  output logic [OP_W-1:0]           apu_op_o,
  input  logic                      apu_gnt_i,
  input  logic                      apu_valid_i,
  input  logic [RES_W-1:0]          apu_result_i,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int ID_W  = $clog2(NUM_CORES);
  localparam int CNT_W = $clog2(MAX_INFLIGHT) + 1;

  arb_state_e      r_state;
  arb_state_e      w_nextState;
  logic [ID_W-1:0] r_rrPtr;
  logic [ID_W-1:0] r_lockId;
  logic            r_err;
  logic [ID_W-1:0] w_search;
  logic [ID_W-1:0] w_winner;
  logic [ID_W-1:0] w_nextPtr;
  logic [ID_W-1:0] w_head;
  logic            w_anyReq;
  logic            w_accept;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic [CNT_W-1:0] w_count;

  // First requester at or after the round-robin pointer wins.
  always_comb begin
    w_search = '0;
    w_anyReq = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!w_anyReq && core_req_i[(int'(r_rrPtr) + i) % NUM_CORES]) begin
        w_search = ID_W'((int'(r_rrPtr) + i) % NUM_CORES);
        w_anyReq = 1'b1;
      end
    end
  end

  assign w_winner  = (r_state == ARB_LOCKED) ? r_lockId : w_search;
  assign apu_req_o = (w_anyReq | (r_state == ARB_LOCKED)) & ~w_full;
  assign apu_op_o  = apu_req_o ? core_op_i[int'(w_winner)*OP_W +: OP_W] : '0;
  assign w_accept  = apu_req_o & apu_gnt_i;
  assign w_nextPtr = (w_winner == ID_W'(NUM_CORES-1)) ? '0 : w_winner + 1'b1;

  assign core_gnt_o    = w_accept ? (NUM_CORES'(1) << w_winner) : '0;
  assign w_pop         = apu_valid_i & ~w_empty;
  assign core_valid_o  = w_pop ? (NUM_CORES'(1) << w_head) : '0;
  assign core_result_o = w_pop ? apu_result_i : '0;
  assign busy_o        = (w_count != '0);
  assign err_o         = r_err;

  // A request the APU did not take freezes the winner until it is granted.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ARB_OPEN:   if (apu_req_o && !apu_gnt_i) w_nextState = ARB_LOCKED;
      ARB_LOCKED: if (w_accept)                w_nextState = ARB_OPEN;
      default:    w_nextState = ARB_OPEN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= ARB_OPEN;
      r_lockId <= '0;
      r_rrPtr  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (r_state == ARB_OPEN && apu_req_o && !apu_gnt_i) r_lockId <= w_winner;
      if (w_accept) r_rrPtr <= w_nextPtr;
      if (apu_valid_i && w_empty) r_err <= 1'b1;
    end
  end

  apu_order_fifo #(
    .DEPTH  (MAX_INFLIGHT),
    .DATA_W (ID_W)
  ) u_orderFifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (w_accept),
    .i_data  (w_winner),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

endmodule

// File: tb/tb_apu_shared_arbiter.sv
// Self-checking bench for apu_shared_arbiter: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_apu_shared_arbiter;

  localparam int N     = 4;
  localparam int OP_W  = 96;
  localparam int RES_W = 32;
  localparam int MAXI  = 4;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [N-1:0]      core_req_i;
  logic [N*OP_W-1:0] core_op_i;
  logic [N-1:0]      core_gnt_o;
  logic [N-1:0]      core_valid_o;
  logic [RES_W-1:0]  core_result_o;
  logic              apu_req_o;
  logic [OP_W-1:0]   apu_op_o;
  logic              apu_gnt_i;
  logic              apu_valid_i;
  logic [RES_W-1:0]  apu_result_i;
  logic              busy_o;
  logic              err_o;

  logic [OP_W-1:0]   opOf [N];

  int checks = 0;
  int errors = 0;

  // Reference model: outstanding issue order, rotation start, held winner.
  int  mQ[$];
  int  mRr;
  bit  mLocked;
  int  mLockId;
  bit  mErr;
  bit  autoDrop;

  bit  expReq, expAccept, expPop, expEmptyErr;
  int  expWin;

  apu_shared_arbiter #(
    .NUM_CORES    (N),
    .OP_W         (OP_W),
    .RES_W        (RES_W),
    .MAX_INFLIGHT (MAXI)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .core_req_i    (core_req_i),
    .core_op_i     (core_op_i),
    .core_gnt_o    (core_gnt_o),
    .core_valid_o  (core_valid_o),
    .core_result_o (core_result_o),
    .apu_req_o     (apu_req_o),
    .apu_op_o      (apu_op_o),
    .apu_gnt_i     (apu_gnt_i),
    .apu_valid_i   (apu_valid_i),
    .apu_result_i  (apu_result_i),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  always_comb begin
    for (int c = 0; c < N; c++) core_op_i[c*OP_W +: OP_W] = opOf[c];
  end

  task automatic cmp(input string tag, input logic [OP_W-1:0] obs, input logic [OP_W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] req, input logic gnt,
                               input logic valid, input logic [RES_W-1:0] res);
    core_req_i   = req;
    apu_gnt_i    = gnt;
    apu_valid_i  = valid;
    apu_result_i = res;
  endtask

  // Compare all outputs against the model; called at posedge+1 with inputs settled.
  task automatic checkOutput(input string tag);
    bit any;
    bit full;
    #3;
    any  = 1'b0;
    expWin = 0;
    full = (mQ.size() == MAXI);
    if (mLocked) begin
      any = 1'b1;
      expWin = mLockId;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!any && core_req_i[(mRr + k) % N]) begin
          any = 1'b1;
          expWin = (mRr + k) % N;
        end
      end
    end
    expReq      = any && !full;
    expAccept   = expReq && apu_gnt_i;
    expPop      = apu_valid_i && (mQ.size() > 0);
    expEmptyErr = apu_valid_i && (mQ.size() == 0);
    cmp({tag, ".apu_req"}, OP_W'(apu_req_o), OP_W'(expReq));
    cmp({tag, ".apu_op"}, apu_op_o, expReq ? opOf[expWin] : '0);
    cmp({tag, ".gnt"}, OP_W'(core_gnt_o), expAccept ? OP_W'(1) << expWin : '0);
    cmp({tag, ".valid"}, OP_W'(core_valid_o), expPop ? OP_W'(1) << mQ[0] : '0);
    cmp({tag, ".result"}, OP_W'(core_result_o), expPop ? OP_W'(apu_result_i) : '0);
    cmp({tag, ".busy"}, OP_W'(busy_o), OP_W'(mQ.size() != 0));
    cmp({tag, ".err"}, OP_W'(err_o), OP_W'(mErr));
  endtask

  task automatic advance();
    @(posedge clk_i);
    if (expPop) void'(mQ.pop_front());
    if (expEmptyErr) mErr = 1'b1;
    if (expAccept) begin
      mQ.push_back(expWin);
      mRr     = (expWin + 1) % N;
      mLocked = 1'b0;
    end else if (expReq) begin
      mLocked = 1'b1;
      mLockId = expWin;
    end
    #1;
    if (expAccept && autoDrop) core_req_i[expWin] = 1'b0;
  endtask

  task automatic doReset(input string tag);
    rst_ni = 1'b0;
    applyStimulus('0, 1'b0, 1'b0, '0);
    mQ.delete();
    mRr = 0; mLocked = 1'b0; mLockId = 0; mErr = 1'b0;
    autoDrop = 1'b1;
    checkOutput(tag);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    logic [N-1:0] seqGnt [5];
    logic [N-1:0] seqVal [3];
    seqGnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    seqVal = '{4'b0100, 4'b0001, 4'b1000};
    for (int c = 0; c < N; c++) opOf[c] = {$urandom, $urandom, $urandom};
    rst_ni = 1'b1;
    applyStimulus('0, 1'b0, 1'b0, '0);
    #1;
    doReset("reset");

    // Single core issue and result return.
    applyStimulus(4'b0001, 1'b1, 1'b0, '0);
    checkOutput("t1_issue");
    cmp("t1_gnt", OP_W'(core_gnt_o), OP_W'(4'b0001));
    advance();
    applyStimulus(core_req_i, 1'b0, 1'b1, 32'hDEAD);
    checkOutput("t1_resp");
    cmp("t1_valid", OP_W'(core_valid_o), OP_W'(4'b0001));
    cmp("t1_result", OP_W'(core_result_o), OP_W'(32'hDEAD));
    cmp("t1_busy_before", OP_W'(busy_o), OP_W'(1));
    advance();
    applyStimulus(core_req_i, 1'b0, 1'b0, '0);
    checkOutput("t1_idle");
    cmp("t1_busy_after", OP_W'(busy_o), OP_W'(0));
    advance();

    // Fairness with all requests held.
    doReset("t2_reset");
    autoDrop = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b1111, 1'b1, mQ.size() > 0, $urandom);
      checkOutput("t2_fair");
      cmp("t2_gnt_seq", OP_W'(core_gnt_o), OP_W'(seqGnt[i]));
      advance();
    end

    // Lock holds the first winner while the APU stalls.
    doReset("t3_reset");
    applyStimulus(4'b0110, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) core_req_i[0] = 1'b1;
      checkOutput("t3_stall");
      cmp("t3_op_held", apu_op_o, opOf[1]);
      advance();
    end
    apu_gnt_i = 1'b1;
    checkOutput("t3_grant");
    cmp("t3_gnt", OP_W'(core_gnt_o), OP_W'(4'b0010));
    advance();

    // Full FIFO blocks issue, including in the cycle of a pop.
    doReset("t4_reset");
    autoDrop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b1111, 1'b1, 1'b0, '0);
      checkOutput("t4_fill");
      advance();
    end
    applyStimulus(4'b1111, 1'b1, 1'b1, 32'h1234);
    checkOutput("t4_full_pop");
    cmp("t4_req_blocked", OP_W'(apu_req_o), OP_W'(0));
    cmp("t4_pop_head", OP_W'(core_valid_o), OP_W'(4'b0001));
    advance();
    applyStimulus(4'b1111, 1'b1, 1'b0, '0);
    checkOutput("t4_resume");
    cmp("t4_req_resumed", OP_W'(apu_req_o), OP_W'(1));
    advance();

    // Results are routed in issue order.
    doReset("t5_reset");
    applyStimulus(4'b0100, 1'b1, 1'b0, '0); checkOutput("t5_issue"); advance();
    applyStimulus(4'b0001, 1'b1, 1'b0, '0); checkOutput("t5_issue"); advance();
    applyStimulus(4'b1000, 1'b1, 1'b0, '0); checkOutput("t5_issue"); advance();
    for (int i = 0; i < 3; i++) begin
      applyStimulus('0, 1'b0, 1'b1, $urandom);
      checkOutput("t5_resp");
      cmp("t5_order", OP_W'(core_valid_o), OP_W'(seqVal[i]));
      advance();
    end

    // Orphan result sets the sticky error; reset clears outstanding ops.
    doReset("t6_reset");
    applyStimulus('0, 1'b0, 1'b1, 32'h5555);
    checkOutput("t6_orphan");
    cmp("t6_no_valid", OP_W'(core_valid_o), OP_W'(0));
    advance();
    applyStimulus(4'b0011, 1'b1, 1'b0, '0);
    checkOutput("t6_err_set");
    cmp("t6_err", OP_W'(err_o), OP_W'(1));
    advance();
    checkOutput("t6_issue2");
    advance();
    cmp("t6_busy_pre", OP_W'(busy_o), OP_W'(1));
    doReset("t6_midreset");
    cmp("t6_busy_post", OP_W'(busy_o), OP_W'(0));
    cmp("t6_err_post", OP_W'(err_o), OP_W'(0));

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int c = 0; c < N; c++) begin
        if (!core_req_i[c] && $urandom_range(0, 99) < 30) begin
          opOf[c] = {$urandom, $urandom, $urandom};
          core_req_i[c] = 1'b1;
        end
      end
      apu_gnt_i    = ($urandom_range(0, 99) < 60);
      apu_valid_i  = (mQ.size() > 0) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 3);
      apu_result_i = $urandom;
      checkOutput("rand");
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
